// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the hazard unit.
// Latency: none (constants, types and pure helper functions only).
// Backpressure: none; this package contains no logic.
// Optional feature macro: MDU_MADD_EN enables the accumulate op codes 4-7.
package mdu_pkg;

    localparam int MDU_OP_W = 3;

    localparam logic [MDU_OP_W-1:0] OP_MULT  = 3'd0;
    localparam logic [MDU_OP_W-1:0] OP_MULTU = 3'd1;
    localparam logic [MDU_OP_W-1:0] OP_DIV   = 3'd2;
    localparam logic [MDU_OP_W-1:0] OP_DIVU  = 3'd3;
    localparam logic [MDU_OP_W-1:0] OP_MADD  = 3'd4;
    localparam logic [MDU_OP_W-1:0] OP_MADDU = 3'd5;
    localparam logic [MDU_OP_W-1:0] OP_MSUB  = 3'd6;
    localparam logic [MDU_OP_W-1:0] OP_MSUBU = 3'd7;

    // Default busy lengths; the hazard unit uses the same values.
    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;

`ifdef MDU_MADD_EN
    localparam logic MDU_MADD_ON = 1'b1;
`else
    localparam logic MDU_MADD_ON = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

    // Op codes 4-7 are the accumulate group and only exist with MDU_MADD_EN.
    function automatic logic op_valid(input logic [MDU_OP_W-1:0] op);
        return (op[2] == 1'b0) || MDU_MADD_ON;
    endfunction

    function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 2*WIDTH result generator for multiply, divide and accumulate.
// Latency: 0 cycles (pure combinational; result is registered by the caller).
// Backpressure: none; output follows inputs every cycle.
// Ports: op, src_a (dividend/multiplicand), src_b (divisor/multiplier),
//        acc ({HI,LO} accumulator input), result ({HI,LO} value to commit).
// Macro: MDU_MADD_EN adds the 2*WIDTH accumulate adder/subtractor.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [MDU_OP_W-1:0]  op,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    input  logic [2*WIDTH-1:0]   acc,
    output logic [2*WIDTH-1:0]   result
);

    // Every signed op code is even, every unsigned one odd.
    logic                 signed_op;
    logic [2*WIDTH-1:0]   ext_a;
    logic [2*WIDTH-1:0]   ext_b;
    logic [2*WIDTH-1:0]   product;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     uq;
    logic [WIDTH-1:0]     ur;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic                 div_zero;

    assign signed_op = ~op[0];

    // A 2W x 2W product truncated to 2W bits equals the exact signed or
    // unsigned product once the operands are extended accordingly.
    assign ext_a   = signed_op ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    assign ext_b   = signed_op ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    assign product = ext_a * ext_b;

    // Signed divide on magnitudes, then restore signs: quotient negative when
    // signs differ (truncation toward zero), remainder follows the dividend.
    // The most-negative / -1 case needs no special path: |MIN| is MIN as an
    // unsigned value, the quotient negates back to MIN and the remainder is 0.
    assign a_neg    = signed_op & src_a[WIDTH-1];
    assign b_neg    = signed_op & src_b[WIDTH-1];
    assign mag_a    = a_neg ? (~src_a + 1'b1) : src_a;
    assign mag_b    = b_neg ? (~src_b + 1'b1) : src_b;
    assign div_zero = (src_b == '0);
    assign divisor  = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    assign uq       = mag_a / divisor;
    assign ur       = mag_a % divisor;
    assign quot     = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
    assign rem      = a_neg ? (~ur + 1'b1) : ur;

`ifndef MDU_MADD_EN
    logic unused_acc;
    assign unused_acc = ^acc;
`endif

    always_comb begin
        result = '0;
        case (op)
            OP_MULT, OP_MULTU: result = product;
            OP_DIV, OP_DIVU: begin
                if (div_zero) result = {src_a, {WIDTH{1'b1}}};
                else          result = {rem, quot};
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: result = acc + product;
            OP_MSUB, OP_MSUBU: result = acc - product;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit for the EX stage with a fixed-length busy window.
// Latency: MUL_CYCLES (mul/acc) or DIV_CYCLES (div) edges from start to commit.
// Backpressure: busy=1 while in flight; start while busy and mthi/mtlo are dropped.
// Ports: clk, reset (sync, active high), start/op/src_a/src_b launch an op,
//        hi_we/lo_we/wdata are mthi/mtlo, busy/hi/lo are the outputs.
// Macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (op codes 4-7).
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MDU_OP_W-1:0]  op,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    input  logic                 hi_we,
    input  logic                 lo_we,
    input  logic [WIDTH-1:0]     wdata,
    output logic                 busy,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_t           state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [2*WIDTH-1:0]   pending, pending_nxt;
    logic [WIDTH-1:0]     hi_nxt, lo_nxt;
    logic [2*WIDTH-1:0]   calc_res;
    logic                 accept;

    // The result is computed at launch from the live {HI,LO}, so the
    // accumulate ops see the value present in the start cycle.
    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .acc    ({hi, lo}),
        .result (calc_res)
    );

    assign accept = (state == ST_IDLE) && start && op_valid(op);
    assign busy   = (state == ST_BUSY);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        hi_nxt      = hi;
        lo_nxt      = lo;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    pending_nxt = calc_res;
                    cnt_nxt     = op_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    state_nxt   = ST_BUSY;
                end else if (!start) begin
                    // A start with an undefined op still blocks mthi/mtlo.
                    if (hi_we) hi_nxt = wdata;
                    if (lo_we) lo_nxt = wdata;
                end
            end
            ST_BUSY: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    hi_nxt    = pending[2*WIDTH-1:WIDTH];
                    lo_nxt    = pending[WIDTH-1:0];
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pending <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised self-checking bench for mul_div_unit against an arithmetic model.
// Latency: checks the exact busy window length and the commit edge of every op.
// Backpressure: exercises start-while-busy, mthi/mtlo while busy and with start.
module tb_mul_div_unit;

    localparam int W     = 32;
    localparam int MUL_N = 5;
    localparam int DIV_N = 10;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          hi_we;
    logic          lo_we;
    logic [W-1:0]  wdata;
    logic          busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference {HI,LO} from the architectural definition of each op.
    function automatic logic [63:0] ref_calc(input int o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        int          ia, ib, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            0: return 64'(sa * sb);
            1: return ua * ub;
            2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == MIN32 && b == 32'hFFFF_FFFF) return {32'd0, MIN32};
                q = ia / ib;
                r = ia % ib;
                return {32'(r), 32'(q)};
            end
            3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            4: return acc + 64'(sa * sb);
            5: return acc + ua * ub;
            6: return acc - 64'(sa * sb);
            7: return acc - ua * ub;
            default: return acc;
        endcase
    endfunction

    // mode: 0 plain, 1 mtlo during busy, 2 mthi with start, 3 start while busy
    task automatic run_op(input int o, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [63:0] exp;
        int          n;
        exp   = ref_calc(o, a, b, {m_hi, m_lo});
        n     = (o == 2 || o == 3) ? DIV_N : MUL_N;
        op    = 3'(o);
        src_a = a;
        src_b = b;
        start = 1'b1;
        if (mode == 2) begin
            hi_we = 1'b1;
            wdata = 32'h55;
        end
        step();
        start = 1'b0;
        hi_we = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        for (int k = 0; k < n; k++) begin
            chk("busy_window", {63'd0, busy}, 64'd1);
            chk("hilo_hold", {hi, lo}, {m_hi, m_lo});
            if (mode == 1 && k == 1) begin
                lo_we = 1'b1;
                wdata = 32'h1234;
            end
            if (mode == 3 && k == 2) begin
                start = 1'b1;
                op    = 3'd0;
            end
            step();
            lo_we = 1'b0;
            start = 1'b0;
        end
        chk("busy_done", {63'd0, busy}, 64'd0);
        chk("commit_hi", {32'd0, hi}, {32'd0, exp[63:32]});
        chk("commit_lo", {32'd0, lo}, {32'd0, exp[31:0]});
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic mt_write(input logic is_hi, input logic [31:0] d);
        hi_we = is_hi;
        lo_we = ~is_hi;
        wdata = d;
        step();
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (is_hi) m_hi = d;
        else       m_lo = d;
        chk("mt_write", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          ro, sel;

        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        src_a = '0;
        src_b = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        step();
        step();
        reset = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);

        // Directed cases
        run_op(0, 32'hFFFF_FFFE, 32'd3, 0);
        chk("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);
        run_op(1, 32'hFFFF_FFFE, 32'd3, 0);
        chk("multu_hi", {32'd0, hi}, 64'h2);
        chk("multu_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);
        run_op(2, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        chk("div_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        run_op(3, 32'd7, 32'd0, 0);
        chk("divu0_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
        chk("divu0_hi", {32'd0, hi}, 64'h7);
        run_op(2, MIN32, 32'hFFFF_FFFF, 0);
        chk("divovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        chk("divovf_hi", {32'd0, hi}, 64'h0);
        run_op(1, 32'd6, 32'd7, 1);
        chk("mtlo_busy_drop", {32'd0, lo}, 64'd42);
        run_op(0, 32'd3, 32'd4, 2);
        chk("mthi_start_drop", {32'd0, hi}, 64'd0);
        run_op(3, 32'd100, 32'd7, 3);
        chk("start_busy_ign", {hi, lo}, {32'd2, 32'd14});

`ifdef MDU_MADD_EN
        mt_write(1'b1, 32'd0);
        mt_write(1'b0, 32'hFFFF_FFFF);
        run_op(5, 32'd1, 32'd1, 0);
        chk("maddu_hi", {32'd0, hi}, 64'd1);
        chk("maddu_lo", {32'd0, lo}, 64'd0);
`else
        mt_write(1'b1, 32'hA5A5_0001);
        mt_write(1'b0, 32'h5A5A_0002);
        for (int o = 4; o < 8; o++) begin
            op    = 3'(o);
            src_a = $urandom;
            src_b = $urandom;
            start = 1'b1;
            hi_we = 1'b1;
            wdata = $urandom;
            step();
            start = 1'b0;
            hi_we = 1'b0;
            chk("undef_op_busy", {63'd0, busy}, 64'd0);
            chk("undef_op_hilo", {hi, lo}, {m_hi, m_lo});
            step();
            chk("undef_op_busy2", {63'd0, busy}, 64'd0);
        end
`endif

        // Randomised ops, back-to-back with occasional idle mthi/mtlo
        for (int i = 0; i < 60; i++) begin
`ifdef MDU_MADD_EN
            ro = int'($urandom_range(0, 7));
`else
            ro = int'($urandom_range(0, 3));
`endif
            ra  = $urandom;
            rb  = $urandom;
            sel = int'($urandom_range(0, 15));
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin
                ra = MIN32;
                rb = 32'hFFFF_FFFF;
            end else if (sel < 5) begin
                ra = 32'($signed(8'($urandom)));
                rb = 32'($signed(4'($urandom)));
            end
            if ($urandom_range(0, 5) == 0) mt_write(1'($urandom), $urandom);
            run_op(ro, ra, rb, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a divide aborts without a late commit
        mt_write(1'b1, 32'h1111_2222);
        mt_write(1'b0, 32'h3333_4444);
        op    = 3'd2;
        src_a = 32'd1000;
        src_b = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_abort_busy", {63'd0, busy}, 64'd0);
        chk("rst_abort_hilo", {hi, lo}, 64'd0);
        for (int k = 0; k < DIV_N + 2; k++) begin
            step();
            chk("rst_no_commit", {31'd0, busy, hi, lo}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
